// File: rtl/sync_sink_pkg.sv
// Shared defaults and handshake state encoding for the sync_sink slice.
// The optional transfer statistics counter is enabled with SYNC_SINK_STAT_EN.
package sync_sink_pkg;

  localparam int BW_DATA_DEF = 8;
  localparam int DEPTH_DEF   = 4;
  localparam int N_SYNC_DEF  = 2;

  // Two-phase handshake has a single bit of state: whether req_s and ack_r differ.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_sink_if.sv
// Bundle of the asynchronous request/ack side and the clocked valid/ready side of sync_sink.
// The master modport is the environment's view; slave is the sink's view.
interface sync_sink_if
  import sync_sink_pkg::*;
#(
  parameter int BW_DATA = BW_DATA_DEF,
  parameter int DEPTH   = DEPTH_DEF
);

  localparam int CW = cnt_width(DEPTH);

  logic               i_in_req;
  logic [BW_DATA-1:0] i_in_data;
  logic               o_in_ack;
  logic [BW_DATA-1:0] o_data;
  logic               o_valid;
  logic               i_ready;
  logic [CW-1:0]      o_count;
  logic [15:0]        o_xfer_cnt;

  modport master (
    output i_in_req, i_in_data, i_ready,
    input  o_in_ack, o_data, o_valid, o_count, o_xfer_cnt
  );

  modport slave (
    input  i_in_req, i_in_data, i_ready,
    output o_in_ack, o_data, o_valid, o_count, o_xfer_cnt
  );

endinterface

// File: rtl/sync_nff.sv
// N-flop single-bit synchroniser with asynchronous active-low reset.
// Shared by the clock-boundary stages of the pipeline; N must be at least 2.
module sync_nff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[N-2:0], d};
    end
  end

  assign q = stages[N-1];

endmodule

// File: rtl/sync_sink.sv
// Tail of the click pipeline: two-phase bundled-data request in, FWFT FIFO, valid/ready out.
// Define SYNC_SINK_STAT_EN to build the 16-bit accepted-transfer counter on o_xfer_cnt.
module sync_sink
  import sync_sink_pkg::*;
#(
  parameter int BW_DATA = BW_DATA_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int N_SYNC  = N_SYNC_DEF
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  sync_sink_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic               req_s;
  logic               ack_r;
  logic [0:0]         hs_state;
  logic               push;
  logic               pop;
  logic [BW_DATA-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;

  sync_nff #(
    .N(N_SYNC)
  ) u_req_sync (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .d     (bus.i_in_req),
    .q     (req_s)
  );

  // Push decision uses the pre-pop count, so a pop never unblocks a push in the same cycle.
  assign hs_state = (req_s != ack_r) ? ST_PEND : ST_IDLE;
  assign push     = (hs_state == ST_PEND) && (count != FULL_COUNT);
  assign pop      = (count != '0) && bus.i_ready;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ack_r  <= 1'b0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= bus.i_in_data;
      wr_ptr      <= wr_ptr + PW'(1);
      ack_r       <= ~ack_r;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.o_in_ack = ack_r;
  assign bus.o_data   = mem[rd_ptr];
  assign bus.o_valid  = (count != '0);
  assign bus.o_count  = count;

`ifdef SYNC_SINK_STAT_EN
  logic [15:0] xfer_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      xfer_cnt <= '0;
    end else if (push) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

  assign bus.o_xfer_cnt = xfer_cnt;
`else
  assign bus.o_xfer_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_sync_sink.sv
// Scoreboard bench for sync_sink: directed handshake/timing cases plus randomized traffic.
// Expected o_xfer_cnt follows SYNC_SINK_STAT_EN.
module tb_sync_sink;

  localparam int BW     = 8;
  localparam int DEPTH  = 4;
  localparam int N_SYNC = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  sync_sink_if #(.BW_DATA(BW), .DEPTH(DEPTH)) bus ();

  sync_sink #(
    .BW_DATA (BW),
    .DEPTH   (DEPTH),
    .N_SYNC  (N_SYNC)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_xfer = 0;
  bit drv_done = 1'b0;
  logic [BW-1:0] sb [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One upstream click: present data, flip req, and record what the sink owes us.
  task automatic applyStimulus(input logic [BW-1:0] d);
    bus.i_in_data = d;
    bus.i_in_req  = ~bus.i_in_req;
    sb.push_back(d);
    exp_xfer++;
  endtask

  task automatic wait_ack(input string name);
    int k = 0;
    while (bus.o_in_ack !== bus.i_in_req && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (bus.o_in_ack !== bus.i_in_req) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: ack timeout, got %0b expected %0b", name, bus.o_in_ack, bus.i_in_req);
    end
  endtask

  task automatic send(input logic [BW-1:0] d);
    applyStimulus(d);
    wait_ack("send_ack");
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (bus.o_count != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (bus.o_count != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: drain timeout, count got %0d expected 0", name, bus.o_count);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: whenever the head will be taken at the next edge, it must match the oldest expected datum.
  always @(negedge clk) begin
    if (rstn && bus.o_valid && bus.i_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL pop_unexpected: got %0h expected none", bus.o_data);
      end else begin
        checkOutput("pop_data", 32'(bus.o_data), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] exp_cnt;
    bus.i_in_req  = 1'b0;
    bus.i_in_data = '0;
    bus.i_ready   = 1'b0;
    rstn          = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ack",   {31'd0, bus.o_in_ack}, 32'd0);
    checkOutput("rst_valid", {31'd0, bus.o_valid},  32'd0);
    checkOutput("rst_count", 32'(bus.o_count),      32'd0);
    checkOutput("rst_data",  32'(bus.o_data),       32'd0);
    checkOutput("rst_xfer",  32'(bus.o_xfer_cnt),   32'd0);
    tick();
    rstn = 1'b1;

    $display("[TB] single transfer");
    tick();
    applyStimulus(8'hA5);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("single_ack_edge1",   {31'd0, bus.o_in_ack}, 32'd0);
    checkOutput("single_valid_edge1", {31'd0, bus.o_valid},  32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("single_ack_edge2",   {31'd0, bus.o_in_ack}, 32'd1);
    checkOutput("single_valid_edge2", {31'd0, bus.o_valid},  32'd1);
    checkOutput("single_data_edge2",  32'(bus.o_data),       32'hA5);
    checkOutput("single_count_edge2", 32'(bus.o_count),      32'd1);
    tick();
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("single_count_after_pop", 32'(bus.o_count), 32'd0);
    tick();
    bus.i_ready = 1'b0;

    $display("[TB] fill to full");
    for (int i = 1; i <= 4; i++) send(BW'(i));
    tick();
    applyStimulus(8'd5);
    repeat (6) tick();
    @(negedge clk);
    checkOutput("full_count",    32'(bus.o_count),      32'd4);
    checkOutput("full_ack_held", {31'd0, bus.o_in_ack}, {31'd0, ~bus.i_in_req});
    tick();
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("full_ack_on_pop_edge", {31'd0, bus.o_in_ack}, {31'd0, ~bus.i_in_req});
    checkOutput("full_count_pop_edge",  32'(bus.o_count),      32'd3);
    @(posedge clk);
    @(negedge clk);
    checkOutput("full_ack_next_edge",   {31'd0, bus.o_in_ack}, {31'd0, bus.i_in_req});
    checkOutput("full_count_next_edge", 32'(bus.o_count),      32'd3);
    wait_drain("full_drain");
    tick();
    bus.i_ready = 1'b0;

    $display("[TB] simultaneous push and pop");
    send(8'h11);
    send(8'h22);
    tick();
    applyStimulus(8'h33);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    @(negedge clk);
    checkOutput("pushpop_count", 32'(bus.o_count),      32'd2);
    checkOutput("pushpop_ack",   {31'd0, bus.o_in_ack}, {31'd0, bus.i_in_req});
    tick();
    bus.i_ready = 1'b1;
    wait_drain("pushpop_drain");
    tick();
    bus.i_ready = 1'b0;

    $display("[TB] randomized traffic");
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send(BW'($urandom));
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          tick();
          bus.i_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    tick();
    bus.i_ready = 1'b1;
    wait_drain("random_drain");
    tick();
    bus.i_ready = 1'b0;

    $display("[TB] reset during pending request");
    send(8'h77);
    tick();
    applyStimulus(8'h3C);
    @(posedge clk);
    #1;
    rstn         = 1'b0;
    bus.i_in_req = 1'b0;
    sb.delete();
    exp_xfer     = 0;
    #1;
    checkOutput("midrst_ack",   {31'd0, bus.o_in_ack}, 32'd0);
    checkOutput("midrst_count", 32'(bus.o_count),      32'd0);
    checkOutput("midrst_valid", {31'd0, bus.o_valid},  32'd0);
    checkOutput("midrst_data",  32'(bus.o_data),       32'd0);
    tick();
    rstn = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    checkOutput("postrst_ack",   {31'd0, bus.o_in_ack}, 32'd0);
    checkOutput("postrst_valid", {31'd0, bus.o_valid},  32'd0);
    checkOutput("postrst_count", 32'(bus.o_count),      32'd0);

    send(8'h5A);
    tick();
    bus.i_ready = 1'b1;
    wait_drain("final_drain");
    tick();
    bus.i_ready = 1'b0;
    @(negedge clk);

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
`ifdef SYNC_SINK_STAT_EN
    exp_cnt = 16'(exp_xfer);
`else
    exp_cnt = 16'd0;
`endif
    checkOutput("xfer_cnt", 32'(bus.o_xfer_cnt), 32'(exp_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_sink.md
# sync_sink

Synchronous consumer stage at the tail of the click-based asynchronous pipeline. Accepts two-phase (transition-signalled) bundled-data requests from the last asynchronous stage and synchronises the request into the `i_clk` domain. Captures the data into a small first-word-fall-through FIFO and returns a two-phase acknowledge. Exposes the data to clocked logic through a valid/ready interface.

## Interface
- BW_DATA, 8, data width of bundled data and FIFO entries
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- N_SYNC, 2, request synchroniser flip-flop count; ≥ 2
- i_clk  input  1  sampling clock; all state updates on the rising edge
- i_rstn  input  1  asynchronous, active-low reset
- i_in_req  input  1  two-phase request from the upstream asynchronous stage; every transition announces one datum
- i_in_data  input  BW_DATA  bundled data; stable from the `i_in_req` transition until the matching `o_in_ack` transition
- o_in_ack  output  1  two-phase acknowledge; one transition per accepted datum
- o_data  output  BW_DATA  FIFO head
- o_valid  output  1  FIFO non-empty
- i_ready  input  1  consumer accepts head when high together with `o_valid`
- o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- o_xfer_cnt  output  16  accepted-transfer counter; see Configuration

## Operation
- Reset (`i_rstn`=0, asynchronous): synchroniser chain=0, ack_r=0, read and write pointers=0, count=0, FIFO storage=0, xfer_cnt=0. Outputs: o_in_ack=0, o_valid=0, o_data=0, o_count=0, o_xfer_cnt=0.
- The upstream source shares `i_rstn` and resets its req to 0, so both phases agree after reset.
- Synchroniser: `i_in_req` passes through N_SYNC flops to produce req_s.
- pending = (req_s != ack_r). This is the only handshake state: IDLE when pending=0, PEND when pending=1.
- Push (write): when pending && count<DEPTH, on the clock edge:
  - write `i_in_data` into mem[wr_ptr]
  - wr_ptr++ (wraps modulo DEPTH)
  - ack_r toggles
- ack_r drives `o_in_ack` directly from the flop, with no combinational path.
- After ack_r toggles, ack_r equals req_s, so pending drops. The next upstream toggle needs N_SYNC edges to reach req_s, so a single transition is never captured twice.
- Pop (read): when o_valid && i_ready, rd_ptr++ (wraps modulo DEPTH).
- o_data = mem[rd_ptr], combinational read.
- count: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Full (count=DEPTH): push blocked and stays PEND; the ack is withheld, which stalls the upstream stage. A pop in the same cycle does not unblock the push; the push occurs on the following edge.
- Empty: o_valid=0, and `i_ready` is ignored.

## Timing
- An `i_in_req` transition sampled at edge 0 reaches req_s at edge N_SYNC-1. Push, ack toggle and o_valid rise all occur at edge N_SYNC, provided the FIFO is not full.
- Push-to-pop latency: o_valid is high in the cycle after the push edge, so a pop can occur on the next edge.
- Sustained throughput is at most one datum per N_SYNC+1 cycles, bounded by the synchroniser round trip plus upstream click delay.
- Bundled-data constraint (timing requirement, not checked in RTL): data settling time plus setup must be less than the synchroniser delay.
- Reset asserted mid-transfer: all state clears immediately and any captured or pending data is discarded. On release, the block starts in IDLE with ack=0.

## Configuration
- SYNC_SINK_STAT_EN defined: o_xfer_cnt increments by 1 on every push and wraps from 16'hFFFF to 0. It resets to 0.
- SYNC_SINK_STAT_EN undefined: the counter register is not built, and o_xfer_cnt is tied to 16'd0. The port is always present.

## Structure
- Shared include header (alongside the delay definitions) holds:
  - default BW_DATA, DEPTH and N_SYNC constants
  - the SYNC_SINK_STAT_EN guard
- Sub-module `sync_nff`: parameterised N-flop single-bit synchroniser with asynchronous active-low reset. It is reused by other clock-boundary stages.
- FIFO storage, pointers and handshake control live in `sync_sink`.

## Test plan
- Reset with i_in_req=0 → o_in_ack=0, o_valid=0, o_count=0, o_data=0, o_xfer_cnt=0.
- Single transfer, N_SYNC=2: toggle req with data 8'hA5 → ack toggles and o_valid=1 at edge 2, o_data=8'hA5. Then i_ready=1 → o_count returns to 0 on the next edge.
- Fill with i_ready=0 and DEPTH=4: five req transitions with data 1..5 → four acks, o_count=4, fifth request held in PEND. Raise i_ready → data pops 1,2,3,4, and datum 5 is acked on the edge after the first pop.
- Simultaneous push and pop at count=2 → o_count stays 2 and the order is preserved.
- Reset during PEND, with req toggled but not yet acked → ack=0, count=0, no spurious push after release with req=0.
- With SYNC_SINK_STAT_EN defined: 65537 transfers → o_xfer_cnt=1. Without it: o_xfer_cnt stays 0.
